// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle handshake data memory with byte/half/word/double loads and RMW stores.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned accesses are suppressed and flagged on Err.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [63:0] Addr,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [63:0] Datain,
  output logic [63:0] Dataout,
  output logic        Ready,
  output logic        Busy,
  output logic        Err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [AW+2:0] r_addr;
  logic          r_wr, r_uns, r_err;
  logic [1:0]    r_size;
  logic [63:0]   r_din;
  logic [63:0]   r_mem [DEPTH_WORDS];
  logic          w_accept, w_go, w_mis, w_unused;
  logic [2:0]    w_amask, w_lane;
  logic [5:0]    w_bit;
  logic [AW-1:0] w_idx;
  logic [63:0]   w_rd, w_sh, w_bm, w_wdata, w_load;
  // RESP hands back to IDLE on the same edge a new request may be taken, giving LATENCY+2 throughput
  assign w_accept = Req && (r_state == IDLE || r_state == RESP);
  assign w_go     = r_state == WAIT && r_cnt == 4'd0;
  assign w_amask  = r_size == 2'd0 ? 3'b111 : r_size == 2'd1 ? 3'b110 : r_size == 2'd2 ? 3'b100 : 3'b000;
  assign w_lane   = r_addr[2:0] & w_amask;
  assign w_bit    = {w_lane, 3'b000};
  assign w_idx    = r_addr[3 +: AW];
  assign w_rd     = r_mem[w_idx];
  assign w_sh     = w_rd >> w_bit;
  assign w_bm     = (r_size == 2'd0 ? 64'hFF : r_size == 2'd1 ? 64'hFFFF :
                     r_size == 2'd2 ? 64'hFFFF_FFFF : '1) << w_bit;
  assign w_wdata  = (w_rd & ~w_bm) | ((r_din << w_bit) & w_bm);
  assign w_load   = r_size == 2'd0 ? {{56{~r_uns & w_sh[7]}}, w_sh[7:0]} :
                    r_size == 2'd1 ? {{48{~r_uns & w_sh[15]}}, w_sh[15:0]} :
                    r_size == 2'd2 ? {{32{~r_uns & w_sh[31]}}, w_sh[31:0]} : w_sh;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis = |(r_addr[2:0] & ~w_amask);
`else
  assign w_mis = 1'b0;
`endif
  assign w_unused = &{1'b0, Addr[63:AW+3]};
  assign Ready = r_state == RESP;
  assign Busy  = r_state != IDLE;
  assign Err   = r_err;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
      Dataout <= 64'd0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        r_state <= WAIT;
        r_cnt   <= 4'(LATENCY);
      end else if (r_state == RESP) begin
        r_state <= IDLE;
      end else if (w_go) begin
        r_state <= RESP;
        r_err   <= w_mis;
        if (!w_mis && !r_wr) Dataout <= w_load;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (!Reset && w_accept) begin
      r_addr <= Addr[AW+2:0];
      r_wr   <= Wr;
      r_size <= Size;
      r_uns  <= Unsigned;
      r_din  <= Datain;
    end
  end
  always_ff @(posedge Clk) begin
    if (!Reset && w_go && r_wr && !w_mis) r_mem[w_idx] <= w_wdata;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed-vector bench for dmem_responder (LATENCY=2, DEPTH_WORDS=256).
module tb_dmem_responder;
  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, wr = 1'b0, uns = 1'b0;
  logic [63:0] addr = '0, din = '0;
  logic [1:0]  size = 2'd0;
  logic [63:0] dout;
  logic        ready, busy, err;
  int          n_chk = 0, n_fail = 0;
  logic        exp_mis_err;
  logic [63:0] exp_lw22;
  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .Clk(clk), .Reset(rst), .Req(req), .Wr(wr), .Addr(addr), .Size(size),
    .Unsigned(uns), .Datain(din), .Dataout(dout), .Ready(ready), .Busy(busy), .Err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic xfer(input string tag, input logic w, input logic [63:0] a, input logic [1:0] sz,
                      input logic u, input logic [63:0] d, input logic [63:0] exp_do, input logic exp_err);
    int lat = 0;
    @(negedge clk);
    req = 1'b1; wr = w; addr = a; size = sz; uns = u; din = d;
    @(negedge clk);
    req = 1'b0;
    while (!ready && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(lat), 64'd3);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_do"}, dout, exp_do);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    @(negedge clk);
    chk({tag, "_rdy_drop"}, {62'd0, ready, busy}, 64'd0);
  endtask
  initial begin
    int rdy_at[$];
    logic seen;
`ifdef DMEM_MISALIGN_TRAP_EN
    exp_mis_err = 1'b1; exp_lw22 = 64'h80;
`else
    exp_mis_err = 1'b0; exp_lw22 = 64'hFFFF_FFFF_89AB_CD80;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_do", dout, 64'd0);
    chk("rst_ctl", {61'd0, ready, busy, err}, 64'd0);
    xfer("sd10",   1, 64'h10, 2'd3, 0, 64'h1122_3344_5566_7788, 64'd0, 0);
    xfer("ld10",   0, 64'h10, 2'd3, 0, 64'd0, 64'h1122_3344_5566_7788, 0);
    xfer("sb15",   1, 64'h15, 2'd0, 0, 64'hFFFF_FFFF_FFFF_FFAB, 64'h1122_3344_5566_7788, 0);
    xfer("ld10b",  0, 64'h10, 2'd3, 0, 64'd0, 64'h1122_AB44_5566_7788, 0);
    xfer("lhu16",  0, 64'h16, 2'd1, 1, 64'd0, 64'h1122, 0);
    xfer("sh12",   1, 64'h12, 2'd1, 0, 64'h0000_0000_0000_8001, 64'h1122, 0);
    xfer("lh12",   0, 64'h12, 2'd1, 0, 64'd0, 64'hFFFF_FFFF_FFFF_8001, 0);
    xfer("sw14",   1, 64'h14, 2'd2, 0, 64'h1111_1111_CAFE_F00D, 64'hFFFF_FFFF_FFFF_8001, 0);
    xfer("ld810",  0, 64'h810, 2'd3, 0, 64'd0, 64'hCAFE_F00D_8001_7788, 0);
    xfer("sd20",   1, 64'h20, 2'd3, 0, 64'h0123_4567_89AB_CDEF, 64'hCAFE_F00D_8001_7788, 0);
    xfer("sb20",   1, 64'h20, 2'd0, 0, 64'h1234_5678_90AB_CD80, 64'hCAFE_F00D_8001_7788, 0);
    xfer("lb20",   0, 64'h20, 2'd0, 0, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 0);
    xfer("lbu20",  0, 64'h20, 2'd0, 1, 64'd0, 64'h80, 0);
    xfer("lw22",   0, 64'h22, 2'd2, 0, 64'd0, exp_lw22, exp_mis_err);
    xfer("lwu20",  0, 64'h20, 2'd2, 1, 64'd0, 64'h89AB_CD80, 0);
    xfer("sd30",   1, 64'h30, 2'd3, 0, 64'h5555_AAAA_5555_AAAA, 64'h89AB_CD80, 0);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 64'h30; size = 2'd3; din = '1;
    @(negedge clk);
    req = 1'b0; rst = 1'b1;
    chk("rstw_busy_pre", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_ctl", {61'd0, ready, busy, err}, 64'd0);
    chk("rstw_do", dout, 64'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= ready;
    end
    chk("rstw_noready", 64'(seen), 64'd0);
    xfer("ld30",   0, 64'h30, 2'd3, 0, 64'd0, 64'h5555_AAAA_5555_AAAA, 0);
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 64'h10; size = 2'd3; uns = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 10) req = 1'b0;
      if (ready) rdy_at.push_back(i);
    end
    chk("burst_cnt", 64'(rdy_at.size()), 64'd3);
    if (rdy_at.size() == 3) begin
      chk("burst_p0", 64'(rdy_at[0]), 64'd4);
      chk("burst_p1", 64'(rdy_at[1]), 64'd8);
      chk("burst_p2", 64'(rdy_at[2]), 64'd12);
    end
    chk("burst_do", dout, 64'hCAFE_F00D_8001_7788);
    chk("burst_idle", 64'(busy), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
